zrle_comp: RTL and testbench



---
 rtl/zrle_comp_pkg.sv | 49 ++++
 rtl/zrle_out_reg.sv | 42 ++++
 rtl/zrle_comp.sv | 155 +++++++++++++++
 tb/tb_zrle_comp.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/zrle_comp_pkg.sv
// Shared definitions for the 64-bit compression datapath: mode tags,
// control-word field positions and the ZRL encoder state encoding.
package zrle_comp_pkg;

    localparam int WORD_W = 64;

    // Mode tags carried in [63:62] of the first word of a compressed packet.
    // SR is identified by bit 63 alone; bit 62 is free for the SR encoder.
    localparam logic [1:0] MODE_BPC = 2'b00;
    localparam logic [1:0] MODE_ZRL = 2'b01;
    localparam logic [1:0] MODE_SR  = 2'b10;

    // Control-word field positions.
    localparam int TAG_HI  = 63;
    localparam int TAG_LO  = 62;
    localparam int EOT_BIT = 61;
    localparam int LIT_BIT = 60;
    localparam int RUN_FIELD_W = 60;

    typedef enum logic {
        S_ACC = 1'b0,   // accepting raw words, counting zero runs
        S_LIT = 1'b1    // control word sent, literal still owed
    } zrle_state_t;

    // Build a ZRL control word; run must already fit the configured width.
    function automatic logic [WORD_W-1:0] ctrl_word(
        input logic                   eot,
        input logic                   lit,
        input logic [RUN_FIELD_W-1:0] run
    );
        logic [WORD_W-1:0] w;
        w                 = '0;
        w[TAG_HI:TAG_LO]  = MODE_ZRL;
        w[EOT_BIT]        = eot;
        w[LIT_BIT]        = lit;
        w[RUN_FIELD_W-1:0] = run;
        return w;
    endfunction

    // True when a packet's first word selects the given decompressor mode.
    function automatic logic tag_is_sr(input logic [WORD_W-1:0] w);
        return w[TAG_HI] == MODE_SR[1];
    endfunction

    function automatic logic tag_is_bpc(input logic [WORD_W-1:0] w);
        return w[TAG_HI:TAG_LO] == MODE_BPC;
    endfunction

endpackage

// File: rtl/zrle_out_reg.sv
// Registered output slice shared by the compressors: holds one token word
// with its framing flags and tells the engine when it may load the next one.
module zrle_out_reg
    import zrle_comp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] ld_data,
    input  logic              ld_sop,
    input  logic              ld_eop,
    input  logic              ready_i,
    output logic [WORD_W-1:0] data_o,
    output logic              valid_o,
    output logic              sop_o,
    output logic              eop_o,
    output logic              out_free
);

    // The slot can take a new word when it is empty or being drained now.
    assign out_free = !valid_o || ready_i;

    // Output register: load on request, otherwise hold until transferred.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) begin
            data_o  <= '0;
            valid_o <= 1'b0;
            sop_o   <= 1'b0;
            eop_o   <= 1'b0;
        end else if (load) begin
            data_o  <= ld_data;
            valid_o <= 1'b1;
            sop_o   <= ld_sop;
            eop_o   <= ld_eop;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/zrle_comp.sv
// Zero-run-length compressor: collapses runs of all-zero words into one
// control word and passes nonzero words as literals behind a control word.
module zrle_comp
    import zrle_comp_pkg::*;
#(
    parameter int RUN_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              sop_i,
    input  logic              eop_i,
    output logic [WORD_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              sop_o,
    output logic              eop_o
);

    // Longest run a single control word can carry.
    localparam logic [RUN_W:0] MAX_RUN = {1'b0, {RUN_W{1'b1}}};

    zrle_state_t       state, state_nxt;
    logic [RUN_W-1:0]  run, run_nxt;
    logic [RUN_W-1:0]  run_eff;
    logic [RUN_W:0]    run_inc;
    logic [WORD_W-1:0] lit_q;
    logic              eot_hold;
    logic              sop_pend;
    logic              sop_now;
    logic              accept;
    logic              word_zero;
    logic              out_free;
    logic              load;
    logic              lit_ld;
    logic [WORD_W-1:0] ld_data;
    logic              ld_sop;
    logic              ld_eop;

    zrle_out_reg u_out (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .ld_data  (ld_data),
        .ld_sop   (ld_sop),
        .ld_eop   (ld_eop),
        .ready_i  (ready_i),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .sop_o    (sop_o),
        .eop_o    (eop_o),
        .out_free (out_free)
    );

    // Input handshake; held off during reset and while a literal is owed.
    assign ready_o   = !rst && (state == S_ACC) && out_free;
    assign accept    = valid_i && ready_o;
    assign word_zero = (data_i == '0);

    // A new packet starts its run from zero, dropping any stale count.
    assign run_eff = (accept && sop_i) ? '0 : run;
    assign run_inc = {1'b0, run_eff} + 1'b1;
    assign sop_now = sop_pend || (accept && sop_i);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_ACC;
        else     state <= state_nxt;
    end

    // Next-state logic: a nonzero word owes a literal beat.
    always_comb begin
        // NOTE: every combinational output gets a default first so no
        // path through the case leaves it unassigned and infers a latch.
        state_nxt = state;
        case (state)
            S_ACC: if (accept && !word_zero) state_nxt = S_LIT;
            S_LIT: if (out_free)             state_nxt = S_ACC;
            default:                         state_nxt = S_ACC;
        endcase
    end

    // Output logic: token selection, run update and literal capture.
    always_comb begin
        load    = 1'b0;
        ld_data = '0;
        ld_sop  = 1'b0;
        ld_eop  = 1'b0;
        lit_ld  = 1'b0;
        run_nxt = run;
        case (state)
            S_ACC: begin
                if (accept) begin
                    if (word_zero) begin
                        if (eop_i) begin
                            // Packet ends inside a run: flush it as the last token.
                            load    = 1'b1;
                            ld_data = ctrl_word(1'b1, 1'b0, RUN_FIELD_W'(run_inc));
                            ld_sop  = sop_now;
                            ld_eop  = 1'b1;
                            run_nxt = '0;
                        end else if (run_inc == MAX_RUN) begin
                            // Run field saturated: emit a full-run token.
                            load    = 1'b1;
                            ld_data = ctrl_word(1'b0, 1'b0, RUN_FIELD_W'(MAX_RUN));
                            ld_sop  = sop_now;
                            run_nxt = '0;
                        end else begin
                            run_nxt = run_inc[RUN_W-1:0];
                        end
                    end else begin
                        // Control word announcing the literal; literal follows.
                        load    = 1'b1;
                        ld_data = ctrl_word(eop_i, 1'b1, RUN_FIELD_W'(run_eff));
                        ld_sop  = sop_now;
                        lit_ld  = 1'b1;
                        run_nxt = run_eff;
                    end
                end
            end
            S_LIT: begin
                if (out_free) begin
                    load    = 1'b1;
                    ld_data = lit_q;
                    ld_eop  = eot_hold;
                    run_nxt = '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers: run counter, pending literal, start-of-packet flag.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the literal register is reset too, so a reset mid-packet can
        // never leak a stale literal into the next packet's token stream.
        if (rst) begin
            run      <= '0;
            lit_q    <= '0;
            eot_hold <= 1'b0;
            sop_pend <= 1'b0;
        end else begin
            run <= run_nxt;
            if (lit_ld) begin
                lit_q    <= data_i;
                eot_hold <= eop_i;
            end
            if (load)                sop_pend <= 1'b0;
            else if (accept && sop_i) sop_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_zrle_comp.sv
// Directed bench for zrle_comp with a scoreboard of expected token words.
module tb_zrle_comp;

    logic        clk;
    logic        rst;
    logic [63:0] data_i;
    logic        valid_i;
    logic        ready_o;
    logic        sop_i;
    logic        eop_i;
    logic [63:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic        sop_o;
    logic        eop_o;

    typedef struct {
        logic [63:0] d;
        logic        s;
        logic        e;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    zrle_comp #(.RUN_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .sop_i   (sop_i),
        .eop_i   (eop_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .sop_o   (sop_o),
        .eop_o   (eop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic expect_word(input logic [63:0] d, input logic s, input logic e);
        exp_t x;
        x.d = d;
        x.s = s;
        x.e = e;
        exp_q.push_back(x);
    endtask

    // Scoreboard: every transfer (valid_o & ready_i at the next edge) is
    // compared against the oldest expected token.
    always @(negedge clk) begin
        if (!rst && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_token", data_o, 64'hx);
            end else begin
                exp_t x;
                x = exp_q.pop_front();
                check("tok_data", data_o, x.d);
                check("tok_sop", {63'd0, sop_o}, {63'd0, x.s});
                check("tok_eop", {63'd0, eop_o}, {63'd0, x.e});
            end
        end
    end

    // Present one word and hold it until accepted; reports cycles stalled.
    task automatic send(input logic [63:0] d, input logic s, input logic e, output int waits);
        waits   = 0;
        data_i  = d;
        sop_i   = s;
        eop_i   = e;
        valid_i = 1'b1;
        @(negedge clk);
        while (!ready_o && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (!ready_o) check("send_timeout", {63'd0, ready_o}, 64'd1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        data_i  = '0;
        sop_i   = 1'b0;
        eop_i   = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int w;
        int wsum;
        logic [63:0] snap_d;
        logic        snap_v, snap_s, snap_e;

        rst     = 1'b1;
        data_i  = '0;
        valid_i = 1'b0;
        sop_i   = 1'b0;
        eop_i   = 1'b0;
        ready_i = 1'b1;
        #3;
        check("rst_ready_o", {63'd0, ready_o}, 64'd0);
        check("rst_valid_o", {63'd0, valid_o}, 64'd0);
        check("rst_data_o", data_o, 64'd0);
        check("rst_sop_eop", {62'd0, sop_o, eop_o}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_ready_o", {63'd0, ready_o}, 64'd1);

        // Zero-only packet collapses into one eot token.
        expect_word(64'h6000_0000_0000_0003, 1'b1, 1'b1);
        send(64'd0, 1'b1, 1'b0, w);
        send(64'd0, 1'b0, 1'b0, w);
        send(64'd0, 1'b0, 1'b1, w);
        drain("drain_zero_pkt");

        // Literal inside a packet; one-cycle input stall for the literal beat.
        expect_word(64'h5000_0000_0000_0001, 1'b1, 1'b0);
        expect_word(64'h0000_0000_0000_DEAD, 1'b0, 1'b0);
        expect_word(64'h6000_0000_0000_0001, 1'b0, 1'b1);
        send(64'd0, 1'b1, 1'b0, w);
        check("lit_first_waits", 64'(w), 64'd0);
        send(64'h0000_0000_0000_DEAD, 1'b0, 1'b0, w);
        check("lit_word_waits", 64'(w), 64'd0);
        send(64'd0, 1'b0, 1'b1, w);
        check("after_lit_waits", 64'(w), 64'd1);
        drain("drain_lit_pkt");

        // Long zero run saturates the run field once.
        expect_word(64'h4000_0000_0000_00FF, 1'b1, 1'b0);
        expect_word(64'h6000_0000_0000_002D, 1'b0, 1'b1);
        wsum = 0;
        for (int i = 0; i < 300; i++) begin
            send(64'd0, (i == 0), (i == 299), w);
            wsum += w;
        end
        check("zero_run_throughput", 64'(wsum), 64'd0);
        drain("drain_long_run");

        // Single nonzero word packet.
        expect_word(64'h7000_0000_0000_0000, 1'b1, 1'b0);
        expect_word(64'h0000_0000_0000_0001, 1'b0, 1'b1);
        send(64'h1, 1'b1, 1'b1, w);
        drain("drain_single_lit");

        // Single zero word packet.
        expect_word(64'h6000_0000_0000_0001, 1'b1, 1'b1);
        send(64'h0, 1'b1, 1'b1, w);
        drain("drain_single_zero");

        // Downstream stall of 5 cycles in the middle of a stream.
        expect_word(64'h5000_0000_0000_0000, 1'b1, 1'b0);
        expect_word(64'h0000_0000_0000_000A, 1'b0, 1'b0);
        expect_word(64'h7000_0000_0000_0001, 1'b0, 1'b0);
        expect_word(64'h0000_0000_0000_000B, 1'b0, 1'b1);
        fork
            begin
                send(64'hA, 1'b1, 1'b0, w);
                send(64'h0, 1'b0, 1'b0, w);
                send(64'hB, 1'b0, 1'b1, w);
            end
            begin
                int n;
                n = 0;
                @(posedge clk);
                #1;
                while (!valid_o && n < 50) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                check("stall_saw_valid", {63'd0, valid_o}, 64'd1);
                ready_i = 1'b0;
                snap_d  = data_o;
                snap_v  = valid_o;
                snap_s  = sop_o;
                snap_e  = eop_o;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check("stall_data", data_o, snap_d);
                    check("stall_flags", {61'd0, valid_o, sop_o, eop_o}, {61'd0, snap_v, snap_s, snap_e});
                    check("stall_ready_o", {63'd0, ready_o}, 64'd0);
                end
                @(posedge clk);
                #1;
                ready_i = 1'b1;
            end
        join
        drain("drain_stall");

        // Reset in the middle of an open packet discards the pending run.
        send(64'd0, 1'b1, 1'b0, w);
        send(64'd0, 1'b0, 1'b0, w);
        send(64'd0, 1'b0, 1'b0, w);
        rst = 1'b1;
        #1;
        check("midrst_ready_o", {63'd0, ready_o}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("midrst_valid_o", {63'd0, valid_o}, 64'd0);
        rst = 1'b0;
        expect_word(64'h7000_0000_0000_0000, 1'b0, 1'b0);
        expect_word(64'h0000_0000_0000_0005, 1'b0, 1'b1);
        send(64'h5, 1'b0, 1'b1, w);
        drain("drain_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "time limit");
    end

endmodule
